// File: rtl/mem_port_arbiter.sv
// Purpose: two-port arbiter/sequencer for the unified instruction/data memory of the multi-cycle core.
// Latency: request seen in IDLE at cycle 0 -> mem_en in cycle 1, ack in cycle MEM_LAT+2; period MEM_LAT+3.
// Backpressure: level requests held until ack; cpu_stall = cpu_req & ~cpu_ack holds the core's controller.
//
// Ports:
//   clk, rst (async active-low)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_rdata/cpu_ack/cpu_stall   core port
//   dma_req/dma_we/dma_addr/dma_wdata -> dma_rdata/dma_ack             secondary requester
//   mem_en/mem_we/mem_addr/mem_wdata (registered), mem_rdata           memory port
// Build option: define ARB_ROUND_ROBIN_EN for alternating grants on contention;
// otherwise the core has fixed priority over DMA.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic                owner_dma_q, owner_dma_d;  // 1 = DMA owns the transaction
  logic                we_q, we_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                dma_ack_q, dma_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
  logic                grant_dma;

`ifdef ARB_ROUND_ROBIN_EN
  logic                last_dma_q, last_dma_d;

  // On contention, favour whoever was not granted last; a lone request always wins.
  assign grant_dma = dma_req & (~cpu_req | ~last_dma_q);
`else
  // Fixed priority: DMA only gets an IDLE cycle in which the core is not asking.
  assign grant_dma = dma_req & ~cpu_req;
`endif

  always_comb begin
    state_d     = state_q;
    owner_dma_d = owner_dma_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_dma_d  = last_dma_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (cpu_req || dma_req) begin
          // Attributes are captured here only; the memory strobe is registered
          // so it appears exactly in the ISSUE cycle.
          owner_dma_d = grant_dma;
          we_d        = grant_dma ? dma_we    : cpu_we;
          mem_addr_d  = grant_dma ? dma_addr  : cpu_addr;
          mem_wdata_d = grant_dma ? dma_wdata : cpu_wdata;
          mem_en_d    = 1'b1;
          mem_we_d    = grant_dma ? dma_we    : cpu_we;
`ifdef ARB_ROUND_ROBIN_EN
          last_dma_d  = grant_dma;
`endif
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(MEM_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Counter hitting zero marks the cycle in which mem_rdata is valid.
        if (cnt_d == '0) begin
          if (!we_q) begin
            if (owner_dma_q) dma_rdata_d = mem_rdata;
            else             cpu_rdata_d = mem_rdata;
          end
          if (owner_dma_q) dma_ack_d = 1'b1;
          else             cpu_ack_d = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        // No arbitration here, so a still-high request cannot be re-granted
        // against the ack it is just receiving.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      owner_dma_q <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_dma_q  <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      owner_dma_q <= owner_dma_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_dma_q  <= last_dma_d;
`endif
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign cpu_stall = cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-timestamp reference model.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ack, cpu_stall;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_ack;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one transaction described by its grant cycle.
  int          cyc = 0;
  int          t_start = -1000;
  int          t_free = 0;
  bit          m_dma, m_we;
  bit          m_last_dma = 1'b1;
  logic [31:0] m_addr, m_wdata, m_cap;
  logic [31:0] exp_addr = '0, exp_wdata = '0, exp_crd = '0, exp_drd = '0;
  bit          exp_en = 1'b0, exp_we = 1'b0, exp_cack = 1'b0, exp_dack = 1'b0;
  bit          last_stall;
  logic [31:0] mr_val = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    cpu_req = 1'b0; dma_req = 1'b0;
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_dma_ack", dma_ack, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dma_rdata", dma_rdata, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    t_start = -1000; t_free = cyc; m_last_dma = 1'b1;
    exp_addr = '0; exp_wdata = '0; exp_crd = '0; exp_drd = '0;
    exp_en = 0; exp_we = 0; exp_cack = 0; exp_dack = 0;
  endtask

  // Drive one cycle of inputs, advance the model, then compare the next cycle.
  task automatic run_cycle(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                           input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
    bit g;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
    mem_rdata = mr_val;
    #1;
    last_stall = cpu_stall;
    chk("cpu_stall", cpu_stall, cr & ~exp_cack);
    if (cyc == t_start + 1 + LAT && !m_we) m_cap = mr_val;
    if (cyc >= t_free && (cr || dr)) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (cr && dr) g = !m_last_dma;
      else          g = dr;
      m_last_dma = g;
`else
      g = !cr;
`endif
      m_dma = g;
      m_we = g ? dw : cw;
      m_addr = g ? da : ca;
      m_wdata = g ? dd : cd;
      t_start = cyc;
      t_free = cyc + LAT + 3;
    end
    @(posedge clk); #1;
    cyc++;
    exp_en = (cyc == t_start + 1);
    exp_we = exp_en && m_we;
    if (exp_en) begin exp_addr = m_addr; exp_wdata = m_wdata; end
    exp_cack = (cyc == t_start + LAT + 2) && !m_dma;
    exp_dack = (cyc == t_start + LAT + 2) && m_dma;
    if (cyc == t_start + LAT + 2 && !m_we) begin
      if (m_dma) exp_drd = m_cap;
      else       exp_crd = m_cap;
    end
    chk("mem_en", mem_en, exp_en);
    chk("mem_we", mem_we, exp_we);
    chk("mem_addr", mem_addr, exp_addr);
    chk("mem_wdata", mem_wdata, exp_wdata);
    chk("cpu_ack", cpu_ack, exp_cack);
    chk("dma_ack", dma_ack, exp_dack);
    chk("cpu_rdata", cpu_rdata, exp_crd);
    chk("dma_rdata", dma_rdata, exp_drd);
  endtask

  task automatic idle();
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [20:0] cm, dm, cm_exp, dm_exp;
    logic [4:0]  sm;
    cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_we = 0; dma_addr = 0; dma_wdata = 0;
    mem_rdata = 0;
    apply_reset();
    repeat (2) idle();

    // Reset in the middle of a read: abandoned, no ack afterwards.
    run_cycle(1, 0, 32'h10, 0, 0, 0, 0, 0);
    run_cycle(1, 0, 32'h10, 0, 0, 0, 0, 0);
    apply_reset();
    repeat (4) idle();
    chk("abort_no_ack", cpu_ack, 0);

    // Fresh core read of 0x10.
    mr_val = 32'hDEADBEEF;
    run_cycle(1, 0, 32'h10, 0, 0, 0, 0, 0);
    chk("rd_mem_en_c1", mem_en, 1);
    chk("rd_addr_c1", mem_addr, 32'h10);
    repeat (3) run_cycle(1, 0, 32'h10, 0, 0, 0, 0, 0);
    chk("rd_ack_c4", cpu_ack, 1);
    chk("rd_data_c4", cpu_rdata, 32'hDEADBEEF);
    repeat (2) idle();

    // DMA write alone.
    mr_val = 32'h5555AAAA;
    run_cycle(0, 0, 0, 0, 1, 1, 32'h40, 32'h1234);
    chk("dw_en_c1", mem_en, 1);
    chk("dw_we_c1", mem_we, 1);
    chk("dw_addr_c1", mem_addr, 32'h40);
    chk("dw_wdata_c1", mem_wdata, 32'h1234);
    run_cycle(0, 0, 0, 0, 1, 1, 32'h40, 32'h1234);
    chk("dw_en_c2", mem_en, 0);
    repeat (2) run_cycle(0, 0, 0, 0, 1, 1, 32'h40, 32'h1234);
    chk("dw_ack_c4", dma_ack, 1);
    chk("dw_rdata_keep", dma_rdata, 0);
    chk("dw_cpu_rdata_keep", cpu_rdata, 32'hDEADBEEF);
    repeat (2) idle();

    // Contention: both held; core drops after cycle 14, DMA after its ack.
    cm = '0; dm = '0;
    for (int k = 0; k < 20; k++) begin
      run_cycle(k <= 14, 0, 32'h100 + k, 0, k <= 18, 0, 32'h200 + k, 0);
      cm[k+1] = cpu_ack;
      dm[k+1] = dma_ack;
    end
`ifdef ARB_ROUND_ROBIN_EN
    cm_exp = (21'd1 << 4) | (21'd1 << 14);
    dm_exp = (21'd1 << 9) | (21'd1 << 19);
`else
    cm_exp = (21'd1 << 4) | (21'd1 << 9) | (21'd1 << 14);
    dm_exp = (21'd1 << 19);
`endif
    chk("cont_cpu_ack_cycles", cm, cm_exp);
    chk("cont_dma_ack_cycles", dm, dm_exp);
    repeat (2) idle();

    // Stall window for a core read held through its ack.
    mr_val = 32'hCAFE0001;
    sm = '0;
    for (int k = 0; k < 5; k++) begin
      run_cycle(1, 0, 32'h20, 0, 0, 0, 0, 0);
      sm[k] = last_stall;
    end
    chk("stall_window", sm, 5'b01111);
    idle();

    // Core write whose address changes in cycle 2.
    run_cycle(1, 1, 32'h80, 32'hAA, 0, 0, 0, 0);
    chk("wr_addr_c1", mem_addr, 32'h80);
    run_cycle(1, 1, 32'h80, 32'hAA, 0, 0, 0, 0);
    run_cycle(1, 1, 32'h99, 32'hBB, 0, 0, 0, 0);
    chk("wr_addr_hold_c3", mem_addr, 32'h80);
    chk("wr_wdata_hold_c3", mem_wdata, 32'hAA);
    run_cycle(1, 1, 32'h99, 32'hBB, 0, 0, 0, 0);
    chk("wr_ack_c4", cpu_ack, 1);
    chk("wr_rdata_keep", cpu_rdata, 32'hCAFE0001);
    idle();

    // Request dropped after grant.
    run_cycle(1, 0, 32'h30, 0, 0, 0, 0, 0);
    run_cycle(1, 0, 32'h30, 0, 0, 0, 0, 0);
    run_cycle(0, 0, 32'h30, 0, 0, 0, 0, 0);
    run_cycle(0, 0, 32'h30, 0, 0, 0, 0, 0);
    chk("drop_ack_c4", cpu_ack, 1);
    idle();
    chk("drop_ack_c5", cpu_ack, 0);
    idle();

    // Random traffic with one reset in the middle.
    for (int i = 0; i < 800; i++) begin
      if (i == 400) apply_reset();
      mr_val = $urandom;
      run_cycle($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom, $urandom,
                $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
